// File: rtl/regwr_pkg.sv
// rtl/regwr_pkg.sv - shared types and constants for the register-file write-port arbiter
package regwr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_STALL = 2'd2
    } arb_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         AUX_MAX  = 4;
    localparam int         CNT_W    = 4;
    localparam int         IDX_W    = $clog2(AUX_MAX);

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first valid at or after ptr
module rr_pick
    import regwr_pkg::*;
#(
    parameter int AUX_N = 2
) (
    input  logic [AUX_N-1:0] valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [AUX_N-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < AUX_N; k++) begin
            j = int'(ptr) + k;
            if (j >= AUX_N) begin
                j = j - AUX_N;
            end
            if (!found && valid[j]) begin
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regwr_arb.sv
// rtl/regwr_arb.sv - register-file write-port arbiter, writeback first, aux round-robin
// Optional starvation guard (counter + one-cycle STALL state) under REGWR_ARB_STARVE_EN.
module regwr_arb
    import regwr_pkg::*;
#(
    parameter int AUX_N        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wb_regwrite,
    input  logic [4:0]          wb_wrreg,
    input  logic [31:0]         wb_wrdata,
    input  logic [AUX_N-1:0]    aux_valid,
    input  logic [5*AUX_N-1:0]  aux_wrreg,
    input  logic [32*AUX_N-1:0] aux_wrdata,
    output logic [AUX_N-1:0]    aux_ready,
    output logic                stall_req,
    output logic                regwrite,
    output logic [4:0]          wrreg,
    output logic [31:0]         wrdata
);

    if (AUX_N < 1 || AUX_N > AUX_MAX || STARVE_LIMIT < 1 || STARVE_LIMIT > (1 << CNT_W) - 1) begin : g_bad_cfg
        $error("regwr_arb: parameter out of range");
    end

    logic             wb_active;
    logic             any_valid;
    logic             aux_turn;
    logic             stall_mode;
    logic             granted;
    logic [AUX_N-1:0] pick_grant;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] rr_ptr_next;
    logic [4:0]       sel_reg;
    logic [31:0]      sel_data;

    rr_pick #(.AUX_N(AUX_N)) u_pick (
        .valid (aux_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .found (any_valid)
    );

    assign wb_active   = wb_regwrite && (wb_wrreg != REG_ZERO);
    // In STALL the aux side outranks writeback; otherwise aux only gets a free port.
    assign aux_turn    = any_valid && (!wb_active || stall_mode);
    assign granted     = aux_turn && !reset;
    assign rr_ptr_next = (pick_idx == IDX_W'(AUX_N - 1)) ? '0 : pick_idx + 1'b1;

    always_comb begin
        sel_reg  = REG_ZERO;
        sel_data = '0;
        for (int i = 0; i < AUX_N; i++) begin
            if (pick_grant[i]) begin
                sel_reg  = aux_wrreg[i*5 +: 5];
                sel_data = aux_wrdata[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (granted) begin
            rr_ptr <= rr_ptr_next;
        end
    end

`ifdef REGWR_ARB_STARVE_EN
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_t       state;
    arb_state_t       state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Any grant or an empty aux side clears the wait history.
    always_comb begin
        state_next = ST_IDLE;
        count_next = '0;
        if (!granted && any_valid) begin
            count_next = (count == LIMIT) ? count : count + 1'b1;
            state_next = (count_next >= LIMIT) ? ST_STALL : ST_WAIT;
        end
    end

    assign stall_mode = (state == ST_STALL);
`else
    assign stall_mode = 1'b0;
`endif

    always_comb begin
        aux_ready = '0;
        stall_req = 1'b0;
        regwrite  = 1'b0;
        wrreg     = REG_ZERO;
        wrdata    = '0;
        if (!reset) begin
            stall_req = stall_mode;
            if (aux_turn) begin
                aux_ready = pick_grant;
                wrreg     = sel_reg;
                wrdata    = sel_data;
                regwrite  = (sel_reg != REG_ZERO);
            end else if (wb_active) begin
                regwrite  = 1'b1;
                wrreg     = wb_wrreg;
                wrdata    = wb_wrdata;
            end
        end
    end

endmodule

// File: tb/tb_regwr_arb.sv
// tb/tb_regwr_arb.sv - scoreboard bench for regwr_arb against a behavioural model
module tb_regwr_arb;

    localparam int AUX_N = 2;
    localparam int LIMIT = 4;
`ifdef REGWR_ARB_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic                wb_regwrite;
    logic [4:0]          wb_wrreg;
    logic [31:0]         wb_wrdata;
    logic [AUX_N-1:0]    aux_valid;
    logic [5*AUX_N-1:0]  aux_wrreg;
    logic [32*AUX_N-1:0] aux_wrdata;
    logic [AUX_N-1:0]    aux_ready;
    logic                stall_req;
    logic                regwrite;
    logic [4:0]          wrreg;
    logic [31:0]         wrdata;

    always #5 clk = ~clk;

    regwr_arb #(.AUX_N(AUX_N), .STARVE_LIMIT(LIMIT)) dut (
        .clk         (clk),
        .reset       (reset),
        .wb_regwrite (wb_regwrite),
        .wb_wrreg    (wb_wrreg),
        .wb_wrdata   (wb_wrdata),
        .aux_valid   (aux_valid),
        .aux_wrreg   (aux_wrreg),
        .aux_wrdata  (aux_wrdata),
        .aux_ready   (aux_ready),
        .stall_req   (stall_req),
        .regwrite    (regwrite),
        .wrreg       (wrreg),
        .wrdata      (wrdata)
    );

    typedef struct packed {
        logic             rst;
        logic             regwrite;
        logic [4:0]       wrreg;
        logic [31:0]      wrdata;
        logic [AUX_N-1:0] ready;
        logic             stall;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   m_ptr    = 0;
    int   m_wait   = 0;
    int   m_last_g = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: expected outputs for the current inputs, then advance one clock.
    task automatic cycle(input bit rst);
        exp_t e;
        int   g;
        bit   wb_act, stall, anyv;
        e     = '0;
        e.rst = rst;
        g     = -1;
        if (rst) begin
            m_ptr  = 0;
            m_wait = 0;
        end else begin
            wb_act = wb_regwrite && (wb_wrreg != 5'd0);
            stall  = STARVE && (m_wait == LIMIT);
            anyv   = |aux_valid;
            if (anyv && (!wb_act || stall)) begin
                for (int k = 0; k < AUX_N; k++) begin
                    if (g < 0 && aux_valid[(m_ptr + k) % AUX_N]) g = (m_ptr + k) % AUX_N;
                end
            end
            if (g >= 0) begin
                e.ready[g] = 1'b1;
                e.wrreg    = aux_wrreg[g*5 +: 5];
                e.wrdata   = aux_wrdata[g*32 +: 32];
                e.regwrite = (e.wrreg != 5'd0);
                m_ptr      = (g + 1) % AUX_N;
            end else if (wb_act) begin
                e.regwrite = 1'b1;
                e.wrreg    = wb_wrreg;
                e.wrdata   = wb_wrdata;
            end
            e.stall = stall;
            if (g >= 0 || !anyv) m_wait = 0;
            else if (m_wait < LIMIT) m_wait++;
        end
        m_last_g = g;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("mon_regwrite", 32'(regwrite), 32'(e.regwrite));
            chk("mon_aux_ready", 32'(aux_ready), 32'(e.ready));
            chk("mon_stall_req", 32'(stall_req), 32'(e.stall));
            if (!e.rst) begin
                chk("mon_wrreg", 32'(wrreg), 32'(e.wrreg));
                chk("mon_wrdata", wrdata, e.wrdata);
            end
        end
    end

    task automatic set_aux(input int i, input bit v, input logic [4:0] r, input logic [31:0] d);
        aux_valid[i]           = v;
        aux_wrreg[i*5 +: 5]    = r;
        aux_wrdata[i*32 +: 32] = d;
    endtask

    task automatic starve_run(input int n);
        bit hit;
        for (int c = 0; c < n; c++) begin
            hit = STARVE && (c == LIMIT);
            #1;
            chk("starve_stall", 32'(stall_req), 32'(hit));
            chk("starve_ready", 32'(aux_ready), hit ? 32'd1 : 32'd0);
            if (hit) begin
                chk("starve_wrreg", 32'(wrreg), 32'd12);
                chk("starve_wrdata", wrdata, 32'hCAFE0012);
            end
            cycle(1'b0);
            if (hit) begin
                aux_valid = '0;
                break;
            end
        end
    endtask

    initial begin
        logic [AUX_N-1:0] rr_exp [3];
        rr_exp[0] = 2'b01;
        rr_exp[1] = 2'b10;
        rr_exp[2] = 2'b01;

        reset = 1'b1;
        wb_regwrite = 1'b1; wb_wrreg = 5'd3; wb_wrdata = 32'h1234;
        aux_valid = '0; aux_wrreg = '0; aux_wrdata = '0;
        set_aux(0, 1'b1, 5'd4, 32'h44);
        set_aux(1, 1'b1, 5'd6, 32'h66);
        @(posedge clk);
        #1;
        chk("reset_regwrite", 32'(regwrite), 32'd0);
        chk("reset_ready", 32'(aux_ready), 32'd0);
        cycle(1'b1);
        cycle(1'b1);
        reset = 1'b0;
        aux_valid = '0;

        wb_regwrite = 1'b1; wb_wrreg = 5'd5; wb_wrdata = 32'hDEADBEEF;
        #1;
        chk("wb_regwrite", 32'(regwrite), 32'd1);
        chk("wb_wrreg", 32'(wrreg), 32'd5);
        chk("wb_wrdata", wrdata, 32'hDEADBEEF);
        chk("wb_ready", 32'(aux_ready), 32'd0);
        cycle(1'b0);

        wb_wrreg = 5'd0;
        set_aux(0, 1'b1, 5'd9, 32'h11);
        #1;
        chk("zero_wb_ready", 32'(aux_ready), 32'd1);
        chk("zero_wb_wrreg", 32'(wrreg), 32'd9);
        cycle(1'b0);
        wb_regwrite = 1'b0;
        set_aux(0, 1'b0, 5'd0, 32'h0);
        set_aux(1, 1'b1, 5'd0, 32'h22);
        #1;
        chk("zero_aux_ready", 32'(aux_ready), 32'd2);
        chk("zero_aux_regwrite", 32'(regwrite), 32'd0);
        cycle(1'b0);
        aux_valid = '0;

        reset = 1'b1;
        cycle(1'b1);
        reset = 1'b0;
        set_aux(0, 1'b1, 5'd10, 32'hA0);
        set_aux(1, 1'b1, 5'd11, 32'hB1);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("rr_grant", 32'(aux_ready), 32'(rr_exp[c]));
            cycle(1'b0);
        end
        aux_valid = '0;

        reset = 1'b1;
        cycle(1'b1);
        reset = 1'b0;
        wb_regwrite = 1'b1; wb_wrreg = 5'd7; wb_wrdata = 32'h77;
        set_aux(0, 1'b1, 5'd12, 32'hCAFE0012);
        starve_run(STARVE ? LIMIT + 1 : 100);

        set_aux(0, 1'b1, 5'd12, 32'hCAFE0012);
        for (int c = 0; c < 3; c++) cycle(1'b0);
        reset = 1'b1;
        #1;
        chk("midwait_regwrite", 32'(regwrite), 32'd0);
        chk("midwait_ready", 32'(aux_ready), 32'd0);
        cycle(1'b1);
        reset = 1'b0;
        starve_run(STARVE ? LIMIT + 1 : 10);
        aux_valid = '0;

        for (int n = 0; n < 2000; n++) begin
            reset       = ($urandom_range(99) == 0);
            wb_regwrite = ($urandom_range(3) != 0);
            wb_wrreg    = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
            wb_wrdata   = $urandom;
            for (int i = 0; i < AUX_N; i++) begin
                if (aux_valid[i] && m_last_g == i) aux_valid[i] = $urandom_range(1);
                else if (!aux_valid[i]) aux_valid[i] = ($urandom_range(2) == 0);
                else continue;
                aux_wrreg[i*5 +: 5]    = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
                aux_wrdata[i*32 +: 32] = $urandom;
            end
            cycle(reset);
        end
        reset = 1'b0;

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
